// File: rtl/time_countdown_pkg.sv
// Shared timing definitions: state encoding, default width and mode constants
// common to the countdown timer and the up counter.
package time_countdown_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic ONE_SHOT = 1'b0;
    localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/time_countdown.sv
// Loadable down-counting timer with one-shot and periodic (auto-reload) modes
// and a single-cycle expiry pulse. All outputs are registered.
module time_countdown
    import time_countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             mode,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             expired_q, expired_d;

    // Priority per cycle: load > stop > start > count.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        expired_d = 1'b0;
        if (load) begin
            reload_d = load_value;
            count_d  = load_value;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!stop && start && (count_q != ZERO)) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (enable) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else if (count_q == ONE) begin
                            expired_d = 1'b1;
                            if (mode == PERIODIC) begin
                                count_d = reload_q;
                            end else begin
                                count_d = ZERO;
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (start && (reload_q != ZERO)) begin
                        count_d = reload_q;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
        end
    end

    assign count   = count_q;
    assign busy    = busy_q;
    assign expired = expired_q;

endmodule
